// File: rtl/tri_inv_row_buf.sv
// Column-in / row-out transpose buffer for one SIZE x SIZE complex matrix; FILL then DRAIN, 1 beat/cycle, first row valid the cycle after the last column.
// Backpressure: col_ready_o is high only in FILL, row_valid_o only in DRAIN; a stalled row holds its data and address. Optional TRI_INV_ROW_BUF_MASK_EN zeroes entries above the diagonal.
module tri_inv_row_buf #(
    parameter int SIZE   = 16,
    parameter int ELEM_W = 128,
    localparam int AW    = $clog2(SIZE)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [SIZE-1:0][ELEM_W-1:0] col_i,
    input  logic [AW-1:0]               col_addr_i,
    input  logic                        col_valid_i,
    output logic                        col_ready_o,
    output logic [SIZE-1:0][ELEM_W-1:0] row_o,
    output logic [AW-1:0]               row_addr_o,
    output logic                        row_valid_o,
    input  logic                        row_ready_i,
    input  logic                        flush_i,
    output logic                        err_o,
    output logic                        busy_o
);

    typedef enum logic {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(SIZE - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AW-1:0]       r_col_cnt;
    logic [AW-1:0]       w_col_cnt_nxt;
    logic [AW-1:0]       r_row_ptr;
    logic [AW-1:0]       w_row_ptr_nxt;
    logic                r_err;
    logic                w_err_nxt;
    logic                w_wr_en;
    logic [ELEM_W-1:0]   r_buf [SIZE][SIZE];
    logic [SIZE-1:0][ELEM_W-1:0] w_row;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_FILL;
            r_col_cnt <= '0;
            r_row_ptr <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_col_cnt <= w_col_cnt_nxt;
            r_row_ptr <= w_row_ptr_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Flush wins over any handshake presented in the same cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_col_cnt_nxt = r_col_cnt;
        w_row_ptr_nxt = r_row_ptr;
        w_err_nxt     = r_err;
        w_wr_en       = 1'b0;
        if (flush_i) begin
            w_state_nxt   = S_FILL;
            w_col_cnt_nxt = '0;
            w_row_ptr_nxt = '0;
            w_err_nxt     = 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (col_valid_i) begin
                        if (col_addr_i == r_col_cnt) begin
                            w_wr_en = 1'b1;
                            if (r_col_cnt == LAST) begin
                                w_state_nxt   = S_DRAIN;
                                w_col_cnt_nxt = '0;
                                w_row_ptr_nxt = '0;
                            end else begin
                                w_col_cnt_nxt = r_col_cnt + 1'b1;
                            end
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (row_ready_i) begin
                        if (r_row_ptr == LAST) begin
                            w_state_nxt   = S_FILL;
                            w_row_ptr_nxt = '0;
                        end else begin
                            w_row_ptr_nxt = r_row_ptr + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < SIZE; r++) begin
                for (int c = 0; c < SIZE; c++) begin
                    r_buf[r][c] <= '0;
                end
            end
        end else if (w_wr_en) begin
            for (int r = 0; r < SIZE; r++) begin
`ifdef TRI_INV_ROW_BUF_MASK_EN
                r_buf[r][col_addr_i] <= (r < int'(col_addr_i)) ? '0 : col_i[r];
`else
                r_buf[r][col_addr_i] <= col_i[r];
`endif
            end
        end
    end

    always_comb begin
        w_row = '0;
        for (int c = 0; c < SIZE; c++) begin
            w_row[c] = r_buf[r_row_ptr][c];
        end
    end

    assign row_o       = w_row;
    assign row_addr_o  = r_row_ptr;
    assign col_ready_o = (r_state == S_FILL);
    assign row_valid_o = (r_state == S_DRAIN);
    assign err_o       = r_err;
    assign busy_o      = (r_state == S_DRAIN) | (r_col_cnt != '0);

endmodule

// File: doc/tri_inv_row_buf.md
# tri_inv_row_buf

Transpose buffer directly downstream of the triangular-matrix inverter. It collects the SIZE inverse columns, each carrying SIZE complex elements, through a valid/ready handshake, then streams the same matrix back out row-by-row for the row-oriented consumers that follow. It has two phases, FILL and DRAIN, and holds one full SIZE×SIZE matrix of {imag, real} double-precision pairs.

## Interface
- SIZE, 16, matrix dimension; power of two, ≥2
- ELEM_W, 128, bits per complex element, {imag[127:64], real[63:0]}
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- col_i  in  [SIZE-1:0][ELEM_W-1:0]  inverse column; index r is matrix row r
- col_addr_i  in  $clog2(SIZE)  column index of col_i
- col_valid_i  in  1  column present
- col_ready_o  out  1  buffer can accept a column
- row_o  out  [SIZE-1:0][ELEM_W-1:0]  output row; index c is matrix column c
- row_addr_o  out  $clog2(SIZE)  row index of row_o
- row_valid_o  out  1  row present
- row_ready_i  in  1  consumer accepts row
- flush_i  in  1  synchronous abort to FILL
- err_o  out  1  sticky: a column arrived out of order
- busy_o  out  1  high when not (FILL with zero columns received)

## Operation
- State machine with two states, FILL and DRAIN; reset state is FILL.
- FILL:
  - col_ready_o = 1.
  - On col_valid_i & col_ready_o, if col_addr_i == col_cnt:
    - Write buf[r][col_addr_i] = col_i[r] for all r.
    - col_cnt increments.
  - If col_addr_i != col_cnt: the column is accepted but discarded, err_o is set, and col_cnt does not advance.
  - Accepting column SIZE-1 in order moves to DRAIN. col_cnt wraps to 0 and row_ptr is 0.
- DRAIN:
  - col_ready_o = 0.
  - row_valid_o = 1; row_o = buf[row_ptr]; row_addr_o = row_ptr.
  - On row_valid_o & row_ready_i, row_ptr increments.
  - The handshake at row_ptr == SIZE-1 returns the block to FILL with row_ptr = 0.
  - row_o and row_addr_o stay stable while row_valid_o & ~row_ready_i.
- flush_i:
  - Forces FILL and clears col_cnt, row_ptr and err_o.
  - Buffer contents are kept.
  - Takes priority over any handshake in the same cycle; that handshake is ignored.
- err_o is cleared only by reset or flush_i.
- busy_o = (state == DRAIN) | (col_cnt != 0).

## Timing
- Reset values:
  - col_ready_o = 1.
  - row_valid_o = 0; row_o = 0, since the buffer resets to zero; row_addr_o = 0.
  - err_o = 0; busy_o = 0.
- Reset mid-operation: state, counters and buffer clear immediately, independent of clk_i.
- col_ready_o and row_valid_o are decoded from registered state only. There is no combinational path from any input to any output.
- Latency: the last column is accepted at edge N; row 0 is valid after edge N, in cycle N+1.
- Throughput:
  - One column per cycle in FILL; SIZE cycles minimum.
  - One row per cycle in DRAIN; SIZE cycles minimum.
- Turnaround: the last row handshake at edge M gives col_ready_o = 1 in cycle M+1.
- No overlap: columns for the next matrix wait until DRAIN completes.

## Configuration
- TRI_INV_ROW_BUF_MASK_EN
  - Defined: entries strictly above the diagonal (r < c) are written as zero whatever col_i carries, and synthesis may drop their storage. Row r of the output has zeros at columns c > r.
  - Undefined: every element is stored and output verbatim.

## Test plan
- Reset then idle:
  - Required: col_ready_o = 1, row_valid_o = 0, busy_o = 0, err_o = 0.
  - Then, with no flush or reset in between, accept 16 columns in order with col_i[r] = {64'(r), 64'(c)} and row_ready_i = 1.
  - Required: row k shows row_o[c] = {64'(k), 64'(c)} at row_addr_o = k; exactly 16 row beats in 16 consecutive cycles.
- Backpressure:
  - Hold row_ready_i = 0 for 5 cycles at row 3.
  - Required: row_addr_o stays 3 and row_o stays stable; after release, rows 4..15 follow; col_ready_o = 1 the cycle after row 15.
- Out-of-order column:
  - After column 0, present col_addr_i = 2.
  - Required: err_o = 1 from the next cycle, col_cnt still 1, buf column 2 unchanged.
  - Then columns 1..15 in order: DRAIN still entered and err_o still 1.
- Flush:
  - Assert flush_i in DRAIN at row 7 together with row_ready_i = 1.
  - Required: next cycle state FILL, row_valid_o = 0, err_o = 0, busy_o = 0.
- Asynchronous reset:
  - Drop rst_ni mid-FILL after 9 columns, between clock edges.
  - Required: outputs at reset values immediately; a subsequent DRAIN of a fresh matrix shows no stale data.
- Mask enabled:
  - With TRI_INV_ROW_BUF_MASK_EN, load all-ones columns.
  - Required: row 0 = {ones, 0×15}; row 15 = all ones.
